// File: rtl/iopage_master_if.sv
// iopage_master_if
//   Bundles the CPU data-path request/response signals and the I/O-page
//   register bus signals seen by the I/O-page initiator.
//   master : the initiator (iopage_master) view.
//   slave  : the environment view (CPU side driver plus the OR-ed devices).
//   bus_*     : CPU byte address, write data, rd/wr request levels,
//               byte qualifier, read data, ack and NXM pulses.
//   iopage_*  : 13-bit register address, write data, rd/wr strobes,
//               byte qualifier, OR-ed device read data and decode.
interface iopage_master_if;
    logic [15:0] bus_addr;
    logic [15:0] bus_data_in;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_byte_op;
    logic [15:0] bus_data_out;
    logic        bus_ack;
    logic        bus_nxm;
    logic [12:0] iopage_addr;
    logic [15:0] iopage_data_out;
    logic        iopage_rd;
    logic        iopage_wr;
    logic        iopage_byte_op;
    logic [15:0] iopage_data_in;
    logic        iopage_decode;

    modport master (
        input  bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
        input  iopage_data_in, iopage_decode,
        output bus_data_out, bus_ack, bus_nxm,
        output iopage_addr, iopage_data_out, iopage_rd, iopage_wr, iopage_byte_op
    );

    modport slave (
        output bus_addr, bus_data_in, bus_rd, bus_wr, bus_byte_op,
        output iopage_data_in, iopage_decode,
        input  bus_data_out, bus_ack, bus_nxm,
        input  iopage_addr, iopage_data_out, iopage_rd, iopage_wr, iopage_byte_op
    );
endinterface

// File: rtl/iopage_master.sv
// iopage_master
//   Initiator side of the I/O-page register bus. Takes one CPU access at a
//   time; if the address lies in the I/O page (addr[15:13]==3'b111) it
//   presents the register address, waits for some device to decode it,
//   issues a single-cycle rd/wr strobe and returns ack + read data to the
//   CPU. If nobody decodes within TIMEOUT+1 DECODE cycles it returns NXM.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : iopage_master_if.master (CPU request/response + I/O-page bus)
// Parameters:
//   TIMEOUT : DECODE cycles to wait past the first before NXM (1..15)
module iopage_master #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    iopage_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        STROBE,
        ACK,
        NXM,
        WAITDROP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       is_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            is_write            <= 1'b0;
            bus.bus_data_out    <= '0;
            bus.bus_ack         <= 1'b0;
            bus.bus_nxm         <= 1'b0;
            bus.iopage_addr     <= '0;
            bus.iopage_data_out <= '0;
            bus.iopage_rd       <= 1'b0;
            bus.iopage_wr       <= 1'b0;
            bus.iopage_byte_op  <= 1'b0;
        end else begin
            // Pulses and strobes are single-cycle; only the state that
            // raises them sets them again.
            bus.bus_ack   <= 1'b0;
            bus.bus_nxm   <= 1'b0;
            bus.iopage_rd <= 1'b0;
            bus.iopage_wr <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if ((bus.bus_rd || bus.bus_wr) && bus.bus_addr[15:13] == 3'b111) begin
                        bus.iopage_addr    <= bus.bus_addr[12:0];
                        bus.iopage_byte_op <= bus.bus_byte_op;
                        // Write wins when both request levels are high.
                        is_write           <= bus.bus_wr;
                        if (bus.bus_wr)
                            bus.iopage_data_out <= bus.bus_byte_op
                                ? {bus.bus_data_in[7:0], bus.bus_data_in[7:0]}
                                : bus.bus_data_in;
                        else
                            bus.iopage_data_out <= '0;
                        state <= DECODE;
                    end
                end

                DECODE: begin
                    // A decode in the final waiting cycle still wins over NXM.
                    if (bus.iopage_decode) begin
                        bus.iopage_rd <= ~is_write;
                        bus.iopage_wr <= is_write;
                        state         <= STROBE;
                    end else if (cnt == 4'(TIMEOUT)) begin
                        bus.bus_nxm      <= 1'b1;
                        bus.bus_data_out <= '0;
                        state            <= NXM;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                STROBE: begin
                    // Device read data is taken at the end of the strobe cycle;
                    // byte reads are right-justified from the addressed lane.
                    if (!is_write) begin
                        if (bus.iopage_byte_op)
                            bus.bus_data_out <= bus.iopage_addr[0]
                                ? {8'h00, bus.iopage_data_in[15:8]}
                                : {8'h00, bus.iopage_data_in[7:0]};
                        else
                            bus.bus_data_out <= bus.iopage_data_in;
                    end
                    bus.bus_ack <= 1'b1;
                    state       <= ACK;
                end

                ACK:  state <= WAITDROP;
                NXM:  state <= WAITDROP;

                WAITDROP: begin
                    // Request levels stay up until the CPU sees the response;
                    // wait for them to fall so one request is served once.
                    if (!bus.bus_rd && !bus.bus_wr)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iopage_master.sv
// tb_iopage_master
//   Self-checking bench for iopage_master. Each access is predicted from the
//   block's timing rules (request sampled at edge 0, first DECODE cycle is
//   cycle 1, strobe at decode-delay+2, ack at +3, NXM at TIMEOUT+2) and the
//   outputs are compared on every negative edge.
module tb_iopage_master;
    localparam int TMO   = 8;
    localparam int NEVER = 255;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iopage_master_if bif ();

    iopage_master #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_fmt(input logic [15:0] addr, input logic byte_op,
                                           input logic [15:0] dev);
        if (!byte_op) return dev;
        return addr[0] ? (dev >> 8) & 16'h00ff : dev & 16'h00ff;
    endfunction

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge clk);
            chk("gap_quiet", {28'd0, bif.iopage_rd, bif.iopage_wr, bif.bus_ack, bif.bus_nxm}, 32'd0);
        end
    endtask

    // Called at a negative edge. Drives one CPU access, plays the device
    // (decode asserted from cycle dly+1, data returned while strobed), then
    // holds the request for 'hold' extra cycles before dropping it.
    task automatic do_access(input logic [15:0] addr, input logic wr, input logic both,
                             input logic byte_op, input logic [15:0] wdata,
                             input int dly, input logic [15:0] dev, input int hold);
        bit io, served;
        int resp, win;
        logic [15:0] exp_w;
        io     = (addr[15:13] == 3'b111);
        served = io && (dly <= TMO);
        resp   = !io ? 5 : (served ? dly + 3 : TMO + 2);
        win    = resp + hold;
        exp_w  = byte_op ? {wdata[7:0], wdata[7:0]} : wdata;

        bif.bus_addr      = addr;
        bif.bus_data_in   = wdata;
        bif.bus_wr        = wr;
        bif.bus_rd        = both | ~wr;
        bif.bus_byte_op   = byte_op;
        bif.iopage_decode = 1'b0;

        for (int k = 1; k <= win; k++) begin
            bit e_rd, e_wr, e_ack, e_nxm;
            @(posedge clk);
            #1;
            bif.iopage_decode = io && (k >= dly + 1);
            @(negedge clk);
            e_rd  = served && !wr && (k == dly + 2);
            e_wr  = served &&  wr && (k == dly + 2);
            e_ack = served && (k == dly + 3);
            e_nxm = io && !served && (k == TMO + 2);
            chk("rd_wr_ack_nxm", {28'd0, bif.iopage_rd, bif.iopage_wr, bif.bus_ack, bif.bus_nxm},
                {28'd0, e_rd, e_wr, e_ack, e_nxm});
            if (io && k <= resp) begin
                chk("iopage_addr", {19'd0, bif.iopage_addr}, {19'd0, addr[12:0]});
                chk("iopage_byte_op", {31'd0, bif.iopage_byte_op}, {31'd0, byte_op});
            end
            if (e_wr) chk("iopage_data_out", {16'd0, bif.iopage_data_out}, {16'd0, exp_w});
            if (e_ack && !wr) chk("bus_data_out", {16'd0, bif.bus_data_out},
                                  {16'd0, rd_fmt(addr, byte_op, dev)});
            if (e_nxm) chk("nxm_data_zero", {16'd0, bif.bus_data_out}, 32'd0);
            // Device drives its register only while strobed; noise otherwise.
            bif.iopage_data_in = bif.iopage_rd ? dev : 16'($urandom);
        end
        bif.bus_rd        = 1'b0;
        bif.bus_wr        = 1'b0;
        bif.iopage_decode = 1'b0;
        idle_gap(3);
    endtask

    initial begin
        reset              = 1'b1;
        bif.bus_addr       = '0;
        bif.bus_data_in    = '0;
        bif.bus_rd         = 1'b0;
        bif.bus_wr         = 1'b0;
        bif.bus_byte_op    = 1'b0;
        bif.iopage_data_in = '0;
        bif.iopage_decode  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bif.bus_data_out, bif.bus_ack, bif.bus_nxm, bif.iopage_rd,
                              bif.iopage_wr, bif.iopage_byte_op, 11'd0},
            32'd0);
        chk("reset_iopage", {bif.iopage_addr, bif.iopage_data_out, 3'd0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_access(16'o177776, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'o000340, 0);
        do_access(16'o177777, 1'b1, 1'b0, 1'b1, 16'hC35A, 0, 16'h0000, 0);
        do_access(16'o177777, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h1234, 0);
        do_access(16'o177776, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h1234, 0);
        do_access(16'o177000, 1'b0, 1'b0, 1'b0, 16'h0000, NEVER, 16'h0000, 2);
        do_access(16'o177010, 1'b0, 1'b0, 1'b0, 16'h0000, TMO, 16'hBEEF, 0);
        do_access(16'o177012, 1'b1, 1'b1, 1'b0, 16'hA5C3, TMO + 1, 16'h0000, 0);
        do_access(16'o177001, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 16'h7E81, 0);
        do_access(16'o177570, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h4321, 20);
        do_access(16'o177570, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h8765, 0);
        do_access(16'o001000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h1111, 4);

        // Reset during the strobe cycle aborts the access.
        bif.bus_addr    = 16'o177776;
        bif.bus_rd      = 1'b1;
        bif.bus_byte_op = 1'b0;
        @(posedge clk); #1;
        bif.iopage_decode = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_strobe", {31'd0, bif.iopage_rd}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {bif.bus_data_out, bif.bus_ack, bif.bus_nxm, bif.iopage_rd,
                              bif.iopage_wr, bif.iopage_byte_op, 11'd0},
            32'd0);
        chk("abort_iopage", {bif.iopage_addr, bif.iopage_data_out, 3'd0}, 32'd0);
        reset             = 1'b0;
        bif.bus_rd        = 1'b0;
        bif.iopage_decode = 1'b0;
        idle_gap(2);

        // Randomized accesses.
        for (int t = 0; t < 40; t++) begin
            logic [15:0] a;
            int d;
            a = 16'($urandom);
            if ($urandom_range(7) == 0) a[15:13] = 3'($urandom_range(6));
            else                        a[15:13] = 3'b111;
            d = ($urandom_range(5) == 0) ? NEVER : $urandom_range(TMO + 2);
            do_access(a, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), d,
                      16'($urandom), $urandom_range(4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
